demux_1_5_reg: RTL and testbench
================================

Name: demux_1_5_reg

Overview:
- Registered 1-to-5 distributor: accepts one DW-bit word plus a destination select and writes it into one of five output holding registers.
- Each holding register has its own valid/ack handshake.
- Sits on the result side of the MDR datapath, the opposite end of the 5-to-1 operand mux: it routes a unit output back to one of five consumers (A..E).
- Select decoding is identical to the operand mux: 0..3 map to A..D; any value 4 or above maps to E.

Parameters:
- DW, 4, data width of input word and each holding register
- DW_SEL, 3, select width; must be at least 3

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst_n  input  1  reset, synchronous, active-low
- i_data  input  DW  word to distribute
- i_sel  input  DW_SEL  destination: 0=A, 1=B, 2=C, 3=D, 4 or above=E
- i_valid  input  1  i_data/i_sel valid this cycle
- o_ready  output  1  distributor can accept i_data for the channel named by i_sel this cycle
- o_a, o_b, o_c, o_d, o_e  output  DW each  holding registers A..E
- o_valid  output  5  per-channel full flag; bit0=A .. bit4=E
- i_ack  input  5  per-channel consumer acknowledge; bit0=A .. bit4=E
- o_busy  output  1  OR of o_valid
- o_drop_cnt  output  8  count of cycles with i_valid=1 and o_ready=0; saturates

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - o_a..o_e = 0, o_valid = 5'b00000, o_busy = 0, o_drop_cnt = 0.
  - Reset dominates all other inputs in that cycle.
  - Reset mid-transfer discards all held data; no handshake completes in the reset cycle.
- Decode: target index t = i_sel if i_sel < 4, else 4. Only one channel is targeted per cycle.
- Per-channel state machine, two states:
  - EMPTY (o_valid[k]=0) -> FULL on accept to k.
  - FULL -> EMPTY on i_ack[k]=1 with no accept to k in the same cycle.
  - FULL -> FULL on i_ack[k]=1 with a simultaneous accept to k: the register reloads with the new word and valid stays 1.
  - FULL -> FULL while i_ack[k]=0: the register holds its value and does not change.
- o_ready (combinational):
  - o_ready = ~o_valid[t] | i_ack[t].
  - o_ready depends on i_sel and i_ack and is independent of i_valid.
- Accept = i_valid & o_ready. On accept, the register for t loads i_data at the next edge and o_valid[t] becomes 1.
- Latency: i_data is visible on the target output one cycle after accept.
- Holding registers change only on accept to that channel; non-targeted channels are never disturbed.
- i_ack[k] while o_valid[k]=0 is ignored: no state change, and it is not remembered.
- Multiple i_ack bits may be set at once; each channel clears independently in the same cycle.
- Blocked request: i_valid=1 with o_ready=0.
  - The word is not stored and no state changes.
  - o_drop_cnt increments by 1, saturating at 255.
  - The producer is expected to hold the request; each blocked cycle counts.
- o_busy is registered-equivalent: it is derived from the registered o_valid, with no combinational path from the inputs.
- Select values above 4 (e.g. 5, 7) behave exactly as 4. They are not errors.

Test Plan:
- Reset: hold i_rst_n=0 for 2 cycles with i_valid=1, i_sel=1, i_data=4'hF -> all outputs 0, o_valid=00000, o_drop_cnt=0 after release.
- Basic routing: sequentially send i_sel=0..4 with data 1,2,3,4,5, no acks -> o_a..o_e = 1,2,3,4,5 one cycle after each accept; o_valid=11111; o_busy=1; other channels unchanged at each step.
- Backpressure: channel B full with 4'h2 and i_ack=0; send i_sel=1, i_data=4'h9 for 3 cycles -> o_ready=0, o_b stays 2, o_drop_cnt=3. Then i_ack[1]=1 in the same cycle as the request -> accept, o_b=9, o_valid[1] stays 1.
- Ack/clear: C full; i_ack=5'b00100 with i_valid=0 -> o_valid[2]=0 next cycle, o_c retains its value. i_ack on empty D -> no change; a later send to D is accepted immediately.
- Select aliasing: i_sel=7, i_data=4'hA with E empty -> o_e=A, o_valid=10000. Repeat with E full and no ack -> blocked, drop counter increments.
- Saturation: 300 consecutive blocked requests -> o_drop_cnt=255 and holds. Then reset -> 0.

Source files
------------

// File: rtl/demux_1_5_reg_if.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1_5_reg_if
//  Brief    : Bus bundle for the registered 1-to-5 distributor: producer-side
//             word/select/valid/ready plus the five holding-register outputs,
//             their per-channel valid/ack pairs and status.
//  Revision : 1.0  initial release
// ============================================================================
interface demux_1_5_reg_if #(
  parameter int DW     = 4,
  parameter int DW_SEL = 3
);
  logic [DW-1:0]     i_data;
  logic [DW_SEL-1:0] i_sel;
  logic              i_valid;
  logic              o_ready;
  logic [DW-1:0]     o_a;
  logic [DW-1:0]     o_b;
  logic [DW-1:0]     o_c;
  logic [DW-1:0]     o_d;
  logic [DW-1:0]     o_e;
  logic [4:0]        o_valid;
  logic [4:0]        i_ack;
  logic              o_busy;
  logic [7:0]        o_drop_cnt;

  // Distributor side
  modport slave (
    input  i_data, i_sel, i_valid, i_ack,
    output o_ready, o_a, o_b, o_c, o_d, o_e, o_valid, o_busy, o_drop_cnt
  );

  // Producer / consumer side
  modport master (
    output i_data, i_sel, i_valid, i_ack,
    input  o_ready, o_a, o_b, o_c, o_d, o_e, o_valid, o_busy, o_drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/demux_1_5_reg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1_5_reg
//  Brief    : Registered 1-to-5 distributor. Routes one word into one of five
//             holding registers (A..E) selected by i_sel (4 and above -> E),
//             each with an independent valid/ack handshake, and counts
//             blocked requests in a saturating 8-bit counter.
//  Revision : 1.0  initial release
// ============================================================================
module demux_1_5_reg #(
  parameter int DW     = 4,
  parameter int DW_SEL = 3
) (
  input  wire logic           i_clk,
  input  wire logic           i_rst_n,
  demux_1_5_reg_if.slave      bus
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ch_state_e;

  localparam logic [7:0] C_DROP_MAX = 8'hFF;

  logic [2:0]           w_tgt;
  logic                 w_ready;
  logic                 w_accept;
  logic [4:0]           w_acc_vec;
  logic [4:0]           w_valid;
  logic [4:0][DW-1:0]   data_q;
  logic [7:0]           drop_cnt_q;
  logic [7:0]           drop_cnt_d;

  // Decode the destination and derive the handshake for the targeted channel
  always_comb begin
    w_tgt = 3'd4;
    if (bus.i_sel < DW_SEL'(4)) begin
      w_tgt = bus.i_sel[2:0];
    end
    w_ready   = ~w_valid[w_tgt] | bus.i_ack[w_tgt];
    w_accept  = bus.i_valid & w_ready;
    w_acc_vec = 5'b00000;
    w_acc_vec[w_tgt] = w_accept;
  end

  // One two-state handshake FSM per channel
  for (genvar k = 0; k < 5; k++) begin : g_ch
    ch_state_e st_q;
    ch_state_e st_d;

    // Channel state register
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        st_q <= ST_EMPTY;
      end else begin
        st_q <= st_d;
      end
    end

    // Fill on accept; an ack drains only when no reload arrives the same cycle
    always_comb begin
      st_d = st_q;
      case (st_q)
        ST_EMPTY: if (w_acc_vec[k])      st_d = ST_FULL;
        ST_FULL:  if (w_acc_vec[k])      st_d = ST_FULL;
                  else if (bus.i_ack[k]) st_d = ST_EMPTY;
        default:  st_d = ST_EMPTY;
      endcase
    end

    assign w_valid[k] = (st_q == ST_FULL);
  end

  // Holding registers change only when their own channel accepts a word
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      data_q <= '0;
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (w_acc_vec[k]) begin
          data_q[k] <= bus.i_data;
        end
      end
    end
  end

  // Blocked requests bump the drop counter until it pins at its maximum
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.i_valid && !w_ready && (drop_cnt_q != C_DROP_MAX)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Drop counter register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.o_ready    = w_ready;
  assign bus.o_a        = data_q[0];
  assign bus.o_b        = data_q[1];
  assign bus.o_c        = data_q[2];
  assign bus.o_d        = data_q[3];
  assign bus.o_e        = data_q[4];
  assign bus.o_valid    = w_valid;
  assign bus.o_busy     = |w_valid;
  assign bus.o_drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_1_5_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_1_5_reg
//  Brief    : Self-checking bench for demux_1_5_reg. A behavioural model of
//             the five holding slots and the drop counter predicts every
//             output; directed steps follow by a randomized phase.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux_1_5_reg;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  demux_1_5_reg_if #(.DW(4), .DW_SEL(3)) bus_if ();

  demux_1_5_reg #(.DW(4), .DW_SEL(3)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: slot contents, slot occupancy, blocked-request count
  logic [3:0] m_data [5];
  bit         m_full [5];
  int         m_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] out_of(input int k);
    case (k)
      0: return bus_if.o_a;
      1: return bus_if.o_b;
      2: return bus_if.o_c;
      3: return bus_if.o_d;
      default: return bus_if.o_e;
    endcase
  endfunction

  task automatic check_all(input string ctx);
    logic [4:0] ev;
    bit         eb;
    ev = '0;
    eb = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("%s_out%0d", ctx, k), 32'(out_of(k)), 32'(m_data[k]));
      ev[k] = m_full[k];
      eb    = eb | m_full[k];
    end
    check({ctx, "_valid"}, 32'(bus_if.o_valid), 32'(ev));
    check({ctx, "_busy"},  32'(bus_if.o_busy),  32'(eb));
    check({ctx, "_drop"},  32'(bus_if.o_drop_cnt), 32'(m_drop));
  endtask

  task automatic model_clear();
    for (int k = 0; k < 5; k++) begin
      m_data[k] = 4'h0;
      m_full[k] = 1'b0;
    end
    m_drop = 0;
  endtask

  // Hold reset for n edges with a live request on the bus
  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n          = 1'b0;
    bus_if.i_valid = 1'b1;
    bus_if.i_sel   = 3'd1;
    bus_if.i_data  = 4'hF;
    bus_if.i_ack   = 5'b11111;
    repeat (n) @(posedge clk);
    model_clear();
    #1;
    check_all("rst_hold");
    @(negedge clk);
    rst_n          = 1'b1;
    bus_if.i_valid = 1'b0;
    bus_if.i_ack   = 5'b00000;
    #1;
    check_all("rst_rel");
  endtask

  // One clock of stimulus: check the combinational ready, then the new state
  task automatic step(input string ctx, input logic v, input logic [2:0] sel,
                      input logic [3:0] d, input logic [4:0] ack);
    int t;
    bit exp_ready;
    @(negedge clk);
    bus_if.i_valid = v;
    bus_if.i_sel   = sel;
    bus_if.i_data  = d;
    bus_if.i_ack   = ack;
    t = (int'(sel) < 4) ? int'(sel) : 4;
    exp_ready = !m_full[t] || ack[t];
    #1;
    check({ctx, "_ready"}, 32'(bus_if.o_ready), 32'(exp_ready));
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      if (v && exp_ready && k == t) begin
        m_data[k] = d;
        m_full[k] = 1'b1;
      end else if (ack[k]) begin
        m_full[k] = 1'b0;
      end
    end
    if (v && !exp_ready && m_drop < 255) m_drop++;
    #1;
    check_all(ctx);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    bus_if.i_valid = 1'b0;
    bus_if.i_sel   = 3'd0;
    bus_if.i_data  = 4'h0;
    bus_if.i_ack   = 5'b00000;
    model_clear();

    // Reset with a live request on the bus
    do_reset(2);

    // Basic routing to A..E
    for (int k = 0; k < 5; k++) step("route", 1'b1, 3'(k), 4'(k + 1), 5'b00000);
    check("route_all_full", 32'(bus_if.o_valid), 32'h1F);

    // Backpressure on B, then reload with a simultaneous ack
    repeat (3) step("bp", 1'b1, 3'd1, 4'h9, 5'b00000);
    check("bp_drop3", 32'(bus_if.o_drop_cnt), 32'd3);
    check("bp_hold_b", 32'(bus_if.o_b), 32'h2);
    step("bp_reload", 1'b1, 3'd1, 4'h9, 5'b00010);
    check("bp_b9", 32'(bus_if.o_b), 32'h9);

    // Ack clears C; ack on an already-empty D is ignored
    step("ack_c", 1'b0, 3'd0, 4'h0, 5'b00100);
    step("ack_d", 1'b0, 3'd0, 4'h0, 5'b01000);
    step("ack_d_empty", 1'b0, 3'd0, 4'h0, 5'b01000);
    step("send_d", 1'b1, 3'd3, 4'h7, 5'b00000);

    // Select aliasing onto E
    step("clr_e", 1'b0, 3'd0, 4'h0, 5'b10000);
    step("alias7", 1'b1, 3'd7, 4'hA, 5'b00000);
    check("alias_e", 32'(bus_if.o_e), 32'hA);
    step("alias_blk", 1'b1, 3'd5, 4'hB, 5'b00000);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      step("rand", 1'($urandom), 3'($urandom_range(0, 7)), 4'($urandom),
           5'($urandom) & 5'($urandom));
    end

    // Saturation of the drop counter against a full E
    step("sat_fill", 1'b1, 3'd4, 4'hC, 5'b10000);
    for (int i = 0; i < 300; i++) step("sat", 1'b1, 3'd6, 4'h3, 5'b00000);
    check("sat_255", 32'(bus_if.o_drop_cnt), 32'd255);

    do_reset(1);
    check("sat_rst", 32'(bus_if.o_drop_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
